// File: rtl/adder_serial_if.sv
// Handshake bundle for adder_serial: packed operand bus in, registered sum out.
// The design side uses the slave modport; the producer/consumer side uses master.
interface adder_serial_if #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32
);
  logic [NUM*WIDTH-1:0] i;
  logic                 i_valid;
  logic                 i_ready;
  logic [WIDTH-1:0]     o;
  logic                 o_valid;
  logic                 o_ready;
  logic                 o_ovf;

  modport master (
    output i, i_valid, o_ready,
    input  i_ready, o, o_valid, o_ovf
  );

  modport slave (
    input  i, i_valid, o_ready,
    output i_ready, o, o_valid, o_ovf
  );
endinterface

// File: rtl/adder_serial.sv
// Serial signed adder: sums NUM two's-complement operands, LANES per cycle,
// over K = NUM/LANES cycles, then presents a saturated or wrapped result
// together with an overflow flag under a valid/ready handshake.
module adder_serial #(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int SAT   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  adder_serial_if.slave bus
);

  localparam int K     = NUM / LANES;
  localparam int ACC_W = WIDTH + $clog2(NUM) + 1;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  // Representable signed range of the result, extended to accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Reject illegal parameterisations at elaboration time.
  if (NUM < 1 || LANES < 1 || (NUM % LANES) != 0) begin : g_param_check
    $error("adder_serial: NUM must be >= 1 and a multiple of LANES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [NUM*WIDTH-1:0]     in_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [WIDTH-1:0]         o_q;
  logic                     o_valid_q;
  logic                     ovf_q;

  logic [WIDTH-1:0]         op;
  logic signed [ACC_W-1:0]  chunk_sum;
  logic signed [ACC_W-1:0]  sum_d;
  logic [WIDTH-1:0]         fold_d;
  logic                     ovf_d;
  logic                     last_chunk;
  logic                     accept;

  // Ready is high when idle, or when the held result is being consumed so a
  // new transaction can start on the same edge.
  assign bus.i_ready = (state_q == IDLE) || ((state_q == DONE) && bus.o_ready);
  assign accept      = bus.i_valid && bus.i_ready;
  assign last_chunk  = (cnt_q == CNT_W'(K - 1));

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_ovf   = ovf_q;

  // Sign-extend and add the LANES operands of the current chunk.
  always_comb begin
    // NOTE: every variable gets a default before any conditional/loop logic
    // so the block stays purely combinational (no inferred latch).
    chunk_sum = '0;
    op        = '0;
    for (int l = 0; l < LANES; l++) begin
      op        = in_q[(int'(cnt_q) * LANES + l) * WIDTH +: WIDTH];
      chunk_sum = chunk_sum + {{(ACC_W-WIDTH){op[WIDTH-1]}}, op};
    end
  end

  // Final sum, overflow detection and saturate/wrap fold.
  always_comb begin
    sum_d  = acc_q + chunk_sum;
    ovf_d  = (sum_d > MAX_V) || (sum_d < MIN_V);
    fold_d = sum_d[WIDTH-1:0];
    if (SAT != 0) begin
      if (sum_d > MAX_V)      fold_d = MAX_V[WIDTH-1:0];
      else if (sum_d < MIN_V) fold_d = MIN_V[WIDTH-1:0];
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand register is reset too, so a reset leaves no stale
      // operand data that a later transaction could observe.
      state_q   <= IDLE;
      in_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_q    <= bus.i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            o_q       <= fold_d;
            ovf_q     <= ovf_d;
            o_valid_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            if (bus.i_valid) begin
              in_q    <= bus.i;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial.sv
// Directed bench for adder_serial: three instances (SAT=1/LANES=2,
// SAT=0/LANES=2, SAT=1/LANES=4), all NUM=4, WIDTH=8.
module tb_adder_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  adder_serial_if #(.NUM(4), .WIDTH(8)) if0 ();
  adder_serial_if #(.NUM(4), .WIDTH(8)) if1 ();
  adder_serial_if #(.NUM(4), .WIDTH(8)) if2 ();

  adder_serial #(.NUM(4), .WIDTH(8), .LANES(2), .SAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  adder_serial #(.NUM(4), .WIDTH(8), .LANES(2), .SAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  adder_serial #(.NUM(4), .WIDTH(8), .LANES(4), .SAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [31:0] d, input logic v,
                       input logic r);
    case (sel)
      0: begin if0.i = d; if0.i_valid = v; if0.o_ready = r; end
      1: begin if1.i = d; if1.i_valid = v; if1.o_ready = r; end
      default: begin if2.i = d; if2.i_valid = v; if2.o_ready = r; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [7:0] o, output logic ov,
                        output logic vld, output logic rdy);
    case (sel)
      0: begin o = if0.o; ov = if0.o_ovf; vld = if0.o_valid; rdy = if0.i_ready; end
      1: begin o = if1.o; ov = if1.o_ovf; vld = if1.o_valid; rdy = if1.i_ready; end
      default: begin o = if2.o; ov = if2.o_ovf; vld = if2.o_valid; rdy = if2.i_ready; end
    endcase
  endtask

  // One transaction: accept, hold junk on i (valid high) while busy, check
  // exact latency and result, then consume and check the result is held.
  task automatic txn(input int sel, input logic [31:0] d, input int lat,
                     input logic [7:0] exp_o, input logic exp_ovf,
                     input string name);
    logic [7:0] so;
    logic       sov, svld, srdy;
    drive(sel, d, 1'b1, 1'b1);
    #1 sample(sel, so, sov, svld, srdy);
    checks++;
    if (srdy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_ready: got %b want 1", name, srdy);
    end
    step();
    for (int k = 0; k < lat; k++) begin
      drive(sel, 32'hA5A5_A5A5, 1'b1, 1'b1);
      #1 sample(sel, so, sov, svld, srdy);
      checks++;
      if ({svld, srdy} !== 2'b00) begin
        errors++;
        $display("FAIL %s busy%0d valid/ready: got %b%b want 00", name, k, svld, srdy);
      end
      step();
    end
    drive(sel, 32'h0, 1'b0, 1'b1);
    #1 sample(sel, so, sov, svld, srdy);
    checks++;
    if ({svld, so, sov} !== {1'b1, exp_o, exp_ovf}) begin
      errors++;
      $display("FAIL %s result: got valid=%b o=%0d ovf=%b want valid=1 o=%0d ovf=%b",
               name, svld, $signed(so), sov, $signed(exp_o), exp_ovf);
    end
    step();
    #1 sample(sel, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy, so, sov} !== {1'b0, 1'b1, exp_o, exp_ovf}) begin
      errors++;
      $display("FAIL %s after_consume: got valid=%b ready=%b o=%0d ovf=%b want 0 1 %0d %b",
               name, svld, srdy, $signed(so), sov, $signed(exp_o), exp_ovf);
    end
  endtask

  task automatic test_reset();
    logic [7:0] so;
    logic       sov, svld, srdy;
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 32'h0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      sample(s, so, sov, svld, srdy);
      checks++;
      if ({so, sov, svld, srdy} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_state dut%0d: got o=%h ovf=%b valid=%b ready=%b want 00 0 0 1",
                 s, so, sov, svld, srdy);
      end
    end
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_basic();
    txn(0, 32'h0403_0201, 2, 8'd10, 1'b0, "basic_sum10");
  endtask

  task automatic test_guard_bits();
    txn(0, 32'h7F7F_8082, 2, 8'h00, 1'b0, "guard_zero");
  endtask

  task automatic test_saturate();
    txn(0, 32'h6464_64CE, 2, 8'h7F, 1'b1, "sat_pos_clamp");
    txn(1, 32'h6464_64CE, 2, 8'hFA, 1'b1, "wrap_pos");
    txn(0, 32'h8080_8080, 2, 8'h80, 1'b1, "sat_neg_clamp");
  endtask

  task automatic test_backpressure();
    logic [7:0] so;
    logic       sov, svld, srdy;
    drive(0, 32'h0403_0201, 1'b1, 1'b0);
    #1;
    step();
    drive(0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      drive(0, 32'h7F7F_7F7F, 1'b1, 1'b0);
      #1 sample(0, so, sov, svld, srdy);
      checks++;
      if ({svld, srdy, so, sov} !== {1'b1, 1'b0, 8'd10, 1'b0}) begin
        errors++;
        $display("FAIL stall%0d: got valid=%b ready=%b o=%0d ovf=%b want 1 0 10 0",
                 c, svld, srdy, so, sov);
      end
      step();
    end
    drive(0, 32'h0101_0101, 1'b1, 1'b1);
    #1 sample(0, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy} !== 2'b11) begin
      errors++;
      $display("FAIL dual_handshake: got valid=%b ready=%b want 11", svld, srdy);
    end
    step();
    drive(0, 32'h0, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1 sample(0, so, sov, svld, srdy);
      checks++;
      if (svld !== 1'b0) begin
        errors++;
        $display("FAIL chained_busy%0d valid: got %b want 0", c, svld);
      end
      step();
    end
    #1 sample(0, so, sov, svld, srdy);
    checks++;
    if ({svld, so, sov} !== {1'b1, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL chained_result: got valid=%b o=%0d ovf=%b want 1 4 0", svld, so, sov);
    end
    step();
  endtask

  task automatic test_reset_mid_busy();
    logic [7:0] so;
    logic       sov, svld, srdy;
    drive(0, 32'h0403_0201, 1'b1, 1'b1);
    #1;
    step();
    drive(0, 32'h0, 1'b0, 1'b1);
    step();
    rst_n = 1'b0;
    #1 sample(0, so, sov, svld, srdy);
    checks++;
    if ({so, sov, svld, srdy} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got o=%h ovf=%b valid=%b ready=%b want 00 0 0 1",
               so, sov, svld, srdy);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 sample(0, so, sov, svld, srdy);
      checks++;
      if ({svld, srdy} !== 2'b01) begin
        errors++;
        $display("FAIL post_reset%0d: got valid=%b ready=%b want 0 1", c, svld, srdy);
      end
      step();
    end
    txn(0, 32'h0403_0201, 2, 8'd10, 1'b0, "post_reset_txn");
  endtask

  task automatic test_lanes4();
    txn(2, 32'hFFFE_FDFC, 1, 8'hF6, 1'b0, "lanes4_neg10");
  endtask

  task automatic test_back_to_back();
    logic [7:0] so;
    logic       sov, svld, srdy;
    drive(2, 32'hFFFE_FDFC, 1'b1, 1'b1);
    #1;
    step();
    drive(2, 32'h0101_0101, 1'b1, 1'b1);
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_busy1: got valid=%b ready=%b want 00", svld, srdy);
    end
    step();
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy, so, sov} !== {1'b1, 1'b1, 8'hF6, 1'b0}) begin
      errors++;
      $display("FAIL b2b_res1: got valid=%b ready=%b o=%0d ovf=%b want 1 1 -10 0",
               svld, srdy, $signed(so), sov);
    end
    step();
    drive(2, 32'h7F7F_7F7F, 1'b1, 1'b1);
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_busy2: got valid=%b ready=%b want 00", svld, srdy);
    end
    step();
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy, so, sov} !== {1'b1, 1'b1, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL b2b_res2: got valid=%b ready=%b o=%0d ovf=%b want 1 1 4 0",
               svld, srdy, so, sov);
    end
    step();
    drive(2, 32'h0, 1'b0, 1'b1);
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if (svld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy3: got valid=%b want 0", svld);
    end
    step();
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if ({svld, so, sov} !== {1'b1, 8'h7F, 1'b1}) begin
      errors++;
      $display("FAIL b2b_res3: got valid=%b o=%0d ovf=%b want 1 127 1",
               svld, $signed(so), sov);
    end
    step();
    #1 sample(2, so, sov, svld, srdy);
    checks++;
    if ({svld, srdy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_idle: got valid=%b ready=%b want 0 1", svld, srdy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_guard_bits();
    test_backpressure();
    test_saturate();
    test_reset_mid_busy();
    test_lanes4();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_serial.md
ADDER_SERIAL -- requirements
Module: adder_serial

Interface
REQ-001 SHALL have parameter NUM, default 4: number of signed operands per transaction (NUM >= 1).
REQ-002 SHALL have parameter WIDTH, default 32: operand and result width, two's complement.
REQ-003 SHALL have parameter LANES, default 2: operands summed per cycle; NUM SHALL be a multiple of LANES (elaboration error otherwise).
REQ-004 SHALL have parameter SAT, default 1: 1 = saturate result, 0 = wrap result.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i  input  NUM*WIDTH  packed operands; element j = i[j*WIDTH +: WIDTH], element 0 in LSBs.
REQ-008 i_valid  input  1  i holds a transaction.
REQ-009 i_ready  output  1  block accepts a transaction this cycle.
REQ-010 o  output  WIDTH  registered signed sum.
REQ-011 o_valid  output  1  o holds a completed result.
REQ-012 o_ready  input  1  downstream consumes o.
REQ-013 o_ovf  output  1  registered; exact sum was outside signed WIDTH range.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE; K = NUM/LANES chunk cycles.
REQ-015 Acceptance SHALL occur on an edge where i_valid && i_ready; entire i SHALL be captured into an internal register at that edge; later changes on i SHALL not affect the result.
REQ-016 i_ready SHALL be 1 in IDLE, 0 in BUSY, and equal o_ready in DONE (combinational).
REQ-017 On acceptance: accumulator := 0, chunk counter := 0, state := BUSY.
REQ-018 In BUSY each edge SHALL add operands c*LANES .. c*LANES+LANES-1 (c = counter) into the accumulator and increment c.
REQ-019 Accumulator SHALL be WIDTH+clog2(NUM)+1 bits, sign-extended operands; no intermediate overflow is possible.
REQ-020 On the edge adding chunk K-1: o := fold(accumulator + chunk), o_ovf := exact sum > 2^(WIDTH-1)-1 or < -2^(WIDTH-1), state := DONE.
REQ-021 fold: SAT=1 clamps to 2^(WIDTH-1)-1 / -2^(WIDTH-1); SAT=0 keeps low WIDTH bits; o_ovf set identically in both modes.
REQ-022 Latency: o_valid SHALL rise exactly K edges after the acceptance edge (K=1 when LANES=NUM).
REQ-023 o_valid SHALL be 1 only in DONE; o and o_ovf SHALL hold stable while o_valid && !o_ready.
REQ-024 DONE with o_ready=1 and i_valid=0: state := IDLE; o, o_ovf keep last value.
REQ-025 DONE with o_ready=1 and i_valid=1 (same edge): result consumed and new transaction accepted, state := BUSY (no idle bubble).
REQ-026 i_valid in BUSY SHALL be ignored (i_ready=0, nothing captured).

Reset
REQ-027 rst_n low SHALL immediately (no clock) force state IDLE, o=0, o_valid=0, o_ovf=0, accumulator=0, counter=0, input register=0.
REQ-028 Reset mid-BUSY or in DONE SHALL discard the transaction; no result is emitted for it.
REQ-029 After rst_n rises, i_ready SHALL be 1 and the first accepted edge SHALL behave per REQ-017.

Verification (NUM=4, WIDTH=8, LANES=2 unless stated)
REQ-030 SAT=1, i={4,3,2,1} (elem3..0), i_valid 1 cycle -> o_valid high 2 edges after acceptance, o=10, o_ovf=0.
REQ-031 SAT=1, elems {100,100,100,-50} -> o=127, o_ovf=1; same with SAT=0 -> o=-6, o_ovf=1; elems all -128, SAT=1 -> o=-128, o_ovf=1.
REQ-032 Elems {127,127,-128,-126} -> o=0, o_ovf=0 (guard bits absorb intermediate excursion).
REQ-033 o_ready low 5 cycles in DONE -> o, o_ovf, o_valid stable, i_ready=0; then o_ready=1 with i_valid=1 and new i={1,1,1,1} -> both handshakes same edge, o=4 exactly 2 edges later.
REQ-034 rst_n low asynchronously one cycle into BUSY -> o=0, o_valid=0, o_ovf=0 before next edge; after release i_ready=1 and no stale o_valid appears.
REQ-035 LANES=4 (K=1), elems {-1,-2,-3,-4} -> o=-10 one edge after acceptance; back-to-back with o_ready held 1 -> one result every 2 cycles.
